mem_slave: RTL and testbench

MEM_SLAVE -- requirements
Module: mem_slave

---
 rtl/mem_slave.sv | 185 ++++++++++++++++++
 tb/tb_mem_slave.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_slave.sv
// -----------------------------------------------------------------------------
// mem_slave
//
// Single-port word-addressed memory slave with a power-on clear sweep.
//
// After reset is released the block sweeps the whole memory, writing zero to
// one word per clock (INIT). Once the last word is cleared it moves to READY
// and accepts one request per clock, with no stall. Each accepted request
// produces a one-cycle slv_rsp strobe on the following cycle. err qualifies
// that strobe. It flags a request with both wr and rd set, or one whose
// address lies beyond the populated memory. An erroring request has no side
// effects.
//
// Parameters
//   ADDR_WIDTH  address bus width
//   DATA_WIDTH  data bus width
//   MEM_SIZE    number of storage words, 1 .. 2**ADDR_WIDTH
//
// Ports
//   clk        in   clock, all state changes on its rising edge
//   reset      in   asynchronous active-low reset
//   wr         in   write request
//   rd         in   read request
//   addr       in   word address (ADDR_WIDTH)
//   wdata      in   write data (DATA_WIDTH)
//   rdata      out  read data, held until the next successful read response
//   slv_rsp    out  one-cycle response strobe per accepted request
//   err        out  error qualifier, meaningful only while slv_rsp=1
//   init_done  out  high once the clear sweep has completed
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  slv_rsp,
  output logic                  err,
  output logic                  init_done
);

  // Width of a word index into the storage array. A single-word memory still
  // needs one index bit.
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  // MEM_SIZE may equal 2**ADDR_WIDTH. The range check therefore runs one bit
  // wider than the address, so that every address compares as unsigned and no
  // address wraps onto a valid word.
  localparam logic [ADDR_WIDTH:0] MEM_SIZE_EXT = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [IDX_W-1:0]    LAST_IDX     = IDX_W'(MEM_SIZE - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q,   state_d;
  logic [IDX_W-1:0]        sweep_q,   sweep_d;
  logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
  logic                    slv_rsp_q, slv_rsp_d;
  logic                    err_q,     err_d;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_SIZE];

  // Memory write port, shared by the clear sweep and host writes.
  logic                    mem_we;
  logic [IDX_W-1:0]        mem_idx;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Request decode.
  logic                    req;
  logic                    addr_ok;
  logic [IDX_W-1:0]        addr_idx;

  assign req      = wr | rd;
  assign addr_ok  = ({1'b0, addr} < MEM_SIZE_EXT);
  // Only the low bits select a word. This is used solely when addr_ok holds,
  // so the upper address bits are zero at that point.
  assign addr_idx = addr[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    sweep_d   = sweep_q;
    rdata_d   = rdata_q;
    slv_rsp_d = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = sweep_q;
    mem_wdata = '0;

    unique case (state_q)
      ST_INIT: begin
        // Clear one word per clock. Host requests are ignored entirely.
        mem_we  = 1'b1;
        mem_idx = sweep_q;
        if (sweep_q == LAST_IDX) begin
          state_d = ST_READY;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + IDX_W'(1);
        end
      end

      ST_READY: begin
        if (req) begin
          slv_rsp_d = 1'b1;
          err_d     = (wr & rd) | ~addr_ok;
          if (!err_d) begin
            if (wr) begin
              mem_we    = 1'b1;
              mem_idx   = addr_idx;
              mem_wdata = wdata;
            end else begin
              // The storage array is read here, so a read in the cycle after
              // a write to the same word sees the updated contents.
              rdata_d = mem_q[addr_idx];
            end
          end
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together from values sampled before the edge.
    if (!reset) begin
      state_q   <= ST_INIT;
      sweep_q   <= '0;
      rdata_q   <= '0;
      slv_rsp_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      rdata_q   <= rdata_d;
      slv_rsp_q <= slv_rsp_d;
      err_q     <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch. Its contents are cleared only by the
  // INIT sweep, which keeps it mappable onto plain RAM. While reset is held
  // the FSM sits in INIT with the sweep at word 0. Word 0 is therefore
  // rewritten with zero on each clock. Nothing can observe this, because the
  // sweep clears that word again on the first edge after release.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rdata     = rdata_q;
  assign slv_rsp   = slv_rsp_q;
  assign err       = err_q;
  assign init_done = (state_q == ST_READY);

endmodule

// File: tb/tb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_mem_slave
//
// Scoreboard bench for mem_slave.
//
// The driver issues one request per clock. A reference model holds a word
// array and the last read value, and tracks readiness as the number of clock
// edges seen since reset release. For each request the model will accept, the
// driver pushes the expected response (due cycle, err, rdata) into a queue.
//
// A monitor samples on the falling clock edge. It pops and compares an entry
// whenever slv_rsp is high. It flags responses that arrive unexpectedly or not
// at all. It also checks init_done on every cycle and the reset values while
// reset is low.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_slave;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MS = 16;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          wr    = 1'b0;
  logic          rd    = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          slv_rsp;
  logic          err;
  logic          init_done;

  always #5 clk = ~clk;

  mem_slave #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_SIZE  (MS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .rd       (rd),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .slv_rsp  (slv_rsp),
    .err      (err),
    .init_done(init_done)
  );

  typedef struct {
    int            due;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  int            total     = 0;
  int            bad       = 0;
  int            cyc       = 0;
  int            rel_edges = 0;
  logic [DW-1:0] model_mem [MS];
  logic [DW-1:0] model_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Rising edges counted since reset release. The memory is ready once MS of
  // them have passed.
  always @(posedge clk or negedge reset) begin
    if (!reset) rel_edges <= 0;
    else        rel_edges <= rel_edges + 1;
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("reset_rdata",   rdata,   '0);
      check("reset_slv_rsp", slv_rsp, 1'b0);
      check("reset_err",     err,     1'b0);
    end
    check("init_done", init_done, (rel_edges >= MS) ? 1'b1 : 1'b0);
    if (slv_rsp) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got slv_rsp=1 expected none at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        check("rsp_cycle", cyc,   e.due);
        check("rsp_err",   err,   e.err);
        check("rsp_rdata", rdata, e.rdata);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missing_rsp: got slv_rsp=0 expected response due at cycle %0d", e.due);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver and reference model
  // ---------------------------------------------------------------------------
  task automatic issue(input logic w, input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    exp_t e;
    logic e_err;
    int   idx;
    wr    = w;
    rd    = r;
    addr  = a;
    wdata = d;
    idx   = int'(a);
    if ((w | r) && reset && rel_edges >= MS) begin
      e_err = (w & r) || (idx >= MS);
      if (!e_err) begin
        if (w) model_mem[idx] = d;
        else   model_rdata    = model_mem[idx];
      end
      e.due   = cyc + 1;
      e.err   = e_err;
      e.rdata = model_rdata;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, '0, '0);
  endtask

  // A response already in flight is lost when reset asserts, and rdata
  // returns to zero.
  task automatic assert_reset();
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    sb.delete();
    model_rdata = '0;
  endtask

  // Every word reads back as zero by the time the memory is ready, because
  // the clear sweep runs first.
  task automatic release_reset();
    reset = 1'b1;
    for (int i = 0; i < MS; i++) model_mem[i] = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            sel;
    logic [AW-1:0] a;

    // Reset held for a few cycles. The monitor checks the reset values.
    repeat (3) @(posedge clk);
    #1;
    release_reset();

    // Read held through the sweep. Only the request after init completes
    // receives a response.
    repeat (MS + 1) issue(1'b0, 1'b1, AW'(3), '0);

    // Write, then read the same word back on the next cycle.
    issue(1'b1, 1'b0, AW'(5), 32'hDEADBEEF);
    issue(1'b0, 1'b1, AW'(5), '0);

    // wr and rd together: error, word 2 and rdata unchanged.
    issue(1'b1, 1'b0, AW'(2), 32'h0000A5A5);
    issue(1'b1, 1'b1, AW'(2), 32'h00001234);
    issue(1'b0, 1'b1, AW'(2), '0);

    // Out-of-range write and read.
    issue(1'b1, 1'b0, AW'(16), 32'h000000FF);
    for (int i = 0; i < MS; i++) issue(1'b0, 1'b1, AW'(i), '0);
    issue(1'b0, 1'b1, AW'(255), '0);

    // Back-to-back fill, then read-back.
    for (int i = 0; i < MS; i++) issue(1'b1, 1'b0, AW'(i), $urandom);
    for (int i = 0; i < MS; i++) issue(1'b0, 1'b1, AW'(i), '0);

    // Random traffic.
    repeat (400) begin
      sel = $urandom_range(0, 9);
      a   = AW'($urandom_range(0, MS - 1));
      case (sel)
        0, 1:    issue(1'b0, 1'b0, a, $urandom);
        2, 3, 4: issue(1'b1, 1'b0, a, $urandom);
        5, 6, 7: issue(1'b0, 1'b1, a, $urandom);
        8:       issue(1'b1, 1'b1, a, $urandom);
        default: issue(1'($urandom_range(0, 1)), 1'b1,
                       AW'($urandom_range(MS, (1 << AW) - 1)), $urandom);
      endcase
    end

    // Reset during traffic with a response in flight.
    issue(1'b1, 1'b0, AW'(9), 32'hCAFEF00D);
    assert_reset();
    repeat (2) @(posedge clk);
    #1;
    release_reset();

    // Reset asserted again at sweep cycle 7. The sweep must restart from
    // the beginning.
    idle(7);
    assert_reset();
    repeat (2) @(posedge clk);
    #1;
    release_reset();
    idle(MS);
    issue(1'b0, 1'b1, AW'(9), '0);

    idle(3);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
